// File: rtl/dac_scan_ctrl.sv
// Round-robin time-multiplexer sharing one 4-bit DAC across NCH sample-and-hold channels.
// Define DAC_SCAN_CH0_PRIO_EN to give channel 0 fixed priority over the round-robin group.
module dac_scan_ctrl #(
    parameter  int IDW    = 2,
    parameter  int SETTLE = 3,
    localparam int NCH    = 2**IDW
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NCH-1:0]   req,
    input  logic [4*NCH-1:0] data,
    output logic [NCH-1:0]   ack,
    output logic [NCH-1:0]   sh_strobe,
    output logic [3:0]       dac_out,
    output logic [IDW-1:0]   grant_id,
    output logic             busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETTLE,
        S_STROBE,
        S_RELEASE
    } state_t;

    localparam logic [3:0] CNT_LOAD = 4'(SETTLE - 1);

    state_t           state, state_nx;
    logic [3:0]       cnt, cnt_nx;
    logic [IDW-1:0]   rr_ptr, rr_ptr_nx;
    logic [3:0]       dac_nx;
    logic [IDW-1:0]   gid_nx;
    logic             busy_nx;
    logic [NCH-1:0]   ack_nx;

    logic             win_found;
    logic [IDW-1:0]   win_id;
    logic             win_upd_ptr;
    logic [IDW-1:0]   cand;

    // Winner search starts just after the last granted channel and wraps.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        win_found   = 1'b0;
        win_id      = '0;
        win_upd_ptr = 1'b1;
        cand        = '0;
`ifdef DAC_SCAN_CH0_PRIO_EN
        if (req[0]) begin
            win_found   = 1'b1;
            win_upd_ptr = 1'b0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                cand = rr_ptr + IDW'(i + 1);
                if (!win_found && cand != '0 && req[cand]) begin
                    win_found = 1'b1;
                    win_id    = cand;
                end
            end
        end
`else
        for (int i = 0; i < NCH; i++) begin
            cand = rr_ptr + IDW'(i + 1);
            if (!win_found && req[cand]) begin
                win_found = 1'b1;
                win_id    = cand;
            end
        end
`endif
    end

    always_comb begin
        state_nx  = state;
        cnt_nx    = cnt;
        rr_ptr_nx = rr_ptr;
        dac_nx    = dac_out;
        gid_nx    = grant_id;
        busy_nx   = busy;
        ack_nx    = '0;
        case (state)
            S_IDLE: begin
                busy_nx = 1'b0;
                if (win_found) begin
                    dac_nx   = data[{win_id, 2'b00} +: 4];
                    gid_nx   = win_id;
                    busy_nx  = 1'b1;
                    cnt_nx   = CNT_LOAD;
                    state_nx = S_SETTLE;
                    if (win_upd_ptr)
                        rr_ptr_nx = win_id;
                end
            end
            S_SETTLE: begin
                if (cnt != 4'd0) begin
                    cnt_nx = cnt - 4'd1;
                end else begin
                    // Registered strobe lands in the single STROBE-state cycle.
                    ack_nx   = NCH'(1) << grant_id;
                    state_nx = S_STROBE;
                end
            end
            S_STROBE: state_nx = S_RELEASE;
            S_RELEASE: begin
                busy_nx  = 1'b0;
                state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            cnt       <= 4'd0;
            rr_ptr    <= IDW'(NCH - 1);
            dac_out   <= 4'd0;
            grant_id  <= '0;
            busy      <= 1'b0;
            ack       <= '0;
            sh_strobe <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state     <= state_nx;
            cnt       <= cnt_nx;
            rr_ptr    <= rr_ptr_nx;
            dac_out   <= dac_nx;
            grant_id  <= gid_nx;
            busy      <= busy_nx;
            ack       <= ack_nx;
            sh_strobe <= ack_nx;
        end
    end

endmodule
